// File: rtl/conv_window_gen.sv
// conv_window_gen: sliding KxK window generator over an MxM raster-order
// pixel stream. K line buffers of M bytes hold the most recent rows; a window
// is assembled and registered on the accept that completes it, and held
// stable until the consumer takes it.
module conv_window_gen #(
  parameter int M = 10,
  parameter int K = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         pix_in,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic [8*K*K-1:0]   win_out,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [7:0]         win_row,
  output logic [7:0]         win_col,
  output logic               frame_done
);

  // Column/row counters only need to span 0..M-1; slot index spans 0..K-1.
  localparam int CW = $clog2(M);
  localparam int SW = $clog2(K);

  localparam logic [CW-1:0] LAST_POS  = CW'(M - 1);
  localparam logic [CW-1:0] K_M1      = CW'(K - 1);
  localparam logic [CW-1:0] LAST_WIN  = CW'(M - K);
  localparam logic [SW-1:0] LAST_SLOT = SW'(K - 1);
  localparam logic [SW:0]   K_EXT     = (SW + 1)'(K);

  // Input position of the next pixel and the line-buffer slot of its row
  // (in_slot_r always equals in_row_r mod K).
  logic [CW-1:0]      in_row_r;
  logic [CW-1:0]      in_col_r;
  logic [SW-1:0]      in_slot_r;

  // Line buffers: deliberately not reset, every byte read is rewritten
  // by the current frame before any window uses it.
  logic [7:0]         lb_r [0:K-1][0:M-1];

  // Registered window output state.
  logic [8*K*K-1:0]   win_out_r;
  logic               win_valid_r;
  logic [CW-1:0]      win_row_r;
  logic [CW-1:0]      win_col_r;
  logic               frame_done_r;

  // Combinational handshake and assembly signals.
  logic               pix_ready_s;
  logic               accept_s;
  logic               handshake_s;
  logic               complete_s;
  logic               last_win_s;
  logic [CW-1:0]      col_base_s;
  logic [SW:0]        rd_sum_s  [0:K-1];
  logic [SW:0]        rd_full_s [0:K-1];
  logic [SW-1:0]      rd_slot_s [0:K-1];
  logic [8*K*K-1:0]   win_next_s;

  // Handshake decode: the only stall is a held window the consumer refuses.
  always_comb begin
    pix_ready_s = !(win_valid_r && !win_ready);
    accept_s    = pix_valid && pix_ready_s;
    handshake_s = win_valid_r && win_ready;
    complete_s  = accept_s && (in_row_r >= K_M1) && (in_col_r >= K_M1);
    last_win_s  = (win_row_r == LAST_WIN) && (win_col_r == LAST_WIN);
    col_base_s  = in_col_r - K_M1;
  end

  // Map window row i to its line-buffer slot: (in_row - K + 1 + i) mod K,
  // computed as (in_slot + 1 + i) mod K with a single conditional subtract.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      rd_sum_s[i] = {1'b0, in_slot_r} + (SW + 1)'(i + 1);
      if (rd_sum_s[i] >= K_EXT) begin
        rd_full_s[i] = rd_sum_s[i] - K_EXT;
      end else begin
        rd_full_s[i] = rd_sum_s[i];
      end
      rd_slot_s[i] = rd_full_s[i][SW-1:0];
    end
  end

  // Assemble the candidate window; the completing pixel bypasses storage
  // because it is being written in this same cycle.
  always_comb begin
    win_next_s = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        win_next_s[8*(i*K+j) +: 8] = lb_r[rd_slot_s[i]][col_base_s + CW'(j)];
      end
    end
    win_next_s[8*(K*K-1) +: 8] = pix_in;
  end

  // Advance raster position on every accepted pixel; wrap to (0,0) per frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_row_r  <= '0;
      in_col_r  <= '0;
      in_slot_r <= '0;
    end else if (accept_s) begin
      if (in_col_r == LAST_POS) begin
        in_col_r <= '0;
        if (in_row_r == LAST_POS) begin
          in_row_r  <= '0;
          in_slot_r <= '0;
        end else begin
          in_row_r <= in_row_r + CW'(1);
          if (in_slot_r == LAST_SLOT) begin
            in_slot_r <= '0;
          end else begin
            in_slot_r <= in_slot_r + SW'(1);
          end
        end
      end else begin
        in_col_r <= in_col_r + CW'(1);
      end
    end
  end

  // Store each accepted pixel into the slot of its row at its column.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb_r[in_slot_r][in_col_r] <= pix_in;
    end
  end

  // Load a new window on the completing accept; otherwise hold it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_out_r <= '0;
      win_row_r <= '0;
      win_col_r <= '0;
    end else if (complete_s) begin
      win_out_r <= win_next_s;
      win_row_r <= in_row_r - K_M1;
      win_col_r <= col_base_s;
    end
  end

  // Window valid: a load wins over a take so back-to-back windows have no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_valid_r <= 1'b0;
    end else if (complete_s) begin
      win_valid_r <= 1'b1;
    end else if (handshake_s) begin
      win_valid_r <= 1'b0;
    end
  end

  // One-cycle pulse after the bottom-right window of a frame is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= handshake_s && last_win_s;
    end
  end

  assign pix_ready  = pix_ready_s;
  assign win_out    = win_out_r;
  assign win_valid  = win_valid_r;
  assign win_row    = 8'(win_row_r);
  assign win_col    = 8'(win_col_r);
  assign frame_done = frame_done_r;

endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 Parameter M, default 10: square input matrix size in pixels per side; 3 <= M <= 256.
REQ-002 Parameter K, default 3: square kernel/window size; 2 <= K <= M.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 pix_in  input  8  unsigned pixel, raster order (row-major, index r*M+c).
REQ-006 pix_valid  input  1  pix_in valid this cycle.
REQ-007 pix_ready  output  1  block can accept pix_in; a pixel is accepted when pix_valid && pix_ready.
REQ-008 win_out  output  8*K*K  KxK window; byte slot 8*(i*K+j) holds pixel (win_row+i, win_col+j).
REQ-009 win_valid  output  1  win_out/win_row/win_col hold a valid window.
REQ-010 win_ready  input  1  consumer takes the window when win_valid && win_ready.
REQ-011 win_row  output  8  top-left row of the current window.
REQ-012 win_col  output  8  top-left column of the current window.
REQ-013 frame_done  output  1  one-cycle pulse after the last window of a frame is taken.

Function
REQ-014 Input counters in_row/in_col SHALL track the position of the next pixel; in_col increments on every accept, wraps M-1->0 with in_row+1; (M-1,M-1)->(0,0) starts the next frame.
REQ-015 Storage SHALL be K line buffers of M bytes; accepted pixel (r,c) SHALL be written to slot (r mod K), column c.
REQ-016 Accepting pixel (r,c) with r >= K-1 and c >= K-1 SHALL complete window (r-K+1, c-K+1); all other accepts produce no window.
REQ-017 Window assembly SHALL read rows (r-K+1+i) mod K for i=0..K-1; the completing pixel itself SHALL be bypassed into slot (K-1,K-1), not read from storage.
REQ-018 On the completing accept, win_out/win_row/win_col SHALL be registered and win_valid SHALL be 1 from the next cycle (latency 1 cycle from accept).
REQ-019 pix_ready SHALL equal !(win_valid && !win_ready); no other stall source.
REQ-020 While win_valid && !win_ready, win_out, win_row, win_col SHALL remain stable.
REQ-021 Handshake with no completing accept in the same cycle: win_valid SHALL clear next cycle.
REQ-022 Handshake and completing accept in the same cycle: new window SHALL load and win_valid SHALL stay 1 (no bubble, no drop).
REQ-023 Each frame SHALL emit exactly (M-K+1)^2 windows in raster order of (win_row, win_col).
REQ-024 frame_done SHALL pulse 1 for exactly one cycle, the cycle after handshake of window (M-K, M-K).
REQ-025 Pixels of the next frame MAY be accepted before the previous frame's last window is taken, subject to REQ-019; line-buffer slots SHALL never overwrite data of the held window.
REQ-026 Gaps in pix_valid SHALL not alter counters, buffers, or outputs.

Reset
REQ-027 When rst_n=0 at posedge clk: in_row=in_col=0, win_valid=0, win_out=0, win_row=win_col=0, frame_done=0.
REQ-028 Line-buffer contents SHALL NOT be reset; reset mid-frame SHALL discard the partial frame and the next accepted pixel is (0,0).
REQ-029 pix_ready SHALL be 1 in the cycle after reset (follows REQ-019 with win_valid=0).

Verification
REQ-030 M=10,K=3, pix_in=r*M+c, pix_valid=1, win_ready=1 -> win_valid first 1 the cycle after pixel index 22 accepted; win_out bytes slots 0..8 = 0,1,2,10,11,12,20,21,22; win_row=win_col=0.
REQ-031 Same stimulus full frame -> exactly 64 windows; last window win_row=win_col=7, bytes 77,78,79,87,88,89,97,98,99; frame_done one pulse, next cycle.
REQ-032 Hold win_ready=0 from first window -> pix_ready=0 from next cycle, win_out stable for 20 cycles; release -> window (0,1) follows with no window lost or duplicated.
REQ-033 Assert rst_n=0 after 50 accepted pixels, then feed new frame pix_in=(r*M+c+100) mod 256 -> first window bytes 100,101,102,110,111,112,120,121,122; no stale data.
REQ-034 Two back-to-back frames, random pix_valid gaps and random win_ready -> 128 windows total, every window matches a reference model, two frame_done pulses.
